// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit instructions over a req/rdy handshake.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | post-reset bubble, nothing driven
// REQ   | first cycle of a fetch, imem_req asserted at PC
// WAIT  | memory stalled, request held at PC
// VALID | instr/PC2 presented to execute, waiting for retire
// HALT  | HALT retired, absorbing until reset
// ERR   | fetch fault or misaligned target, absorbing until reset
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'h0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PCwb,
    input  logic        pc_load,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        imem_err,
    output logic [15:0] instr,
    output logic [15:0] PC2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] retire_cnt
`endif
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] instr_q, instr_nxt;
    logic        retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ, WAIT: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    if (imem_err) begin
                        state_nxt = ERR;
                    end else begin
                        instr_nxt = imem_data;
                        state_nxt = VALID;
                    end
                end else begin
                    state_nxt = WAIT;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (pc_load) begin
                    retire = 1'b1;
                    // halt wins over any target, and a halting retire never moves the PC
                    if (halt) begin
                        state_nxt = HALT;
                    end else if (PCwb[0]) begin
                        state_nxt = ERR;
                    end else begin
                        pc_nxt    = PCwb;
                        state_nxt = REQ;
                    end
                end
            end
            HALT:    halted = 1'b1;
            ERR:     err = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign instr     = instr_q;
    assign PC2       = pc + PC_INC;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= 16'h0000;
            retire_cnt <= 16'h0000;
        end else begin
            if (state == WAIT && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
            if (retire && retire_cnt != 16'hFFFF) retire_cnt <= retire_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of retire targets plus
// hand-written halt, fault and reset-in-WAIT sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] PCwb;
    logic        pc_load;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        imem_err;
    logic [15:0] instr;
    logic [15:0] PC2;
    logic        instr_valid;
    logic        halted;
    logic        err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] retire_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];
    int exp_stall  = 0;
    int exp_retire = 0;

    typedef struct {
        logic [15:0] pcwb;
        logic [15:0] data;
        int          waits;
        logic [15:0] exp_pc2;
    } vec_t;

    vec_t vecs[5];

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCwb       (PCwb),
        .pc_load    (pc_load),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .imem_err   (imem_err),
        .instr      (instr),
        .PC2        (PC2),
        .instr_valid(instr_valid),
        .halted     (halted),
        .err        (err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_stall  = 0;
        exp_retire = 0;
    endtask

    // Entered with the DUT in REQ; serves one fetch after `waits` stall cycles.
    task automatic serve(input logic [15:0] addr, input logic [15:0] data, input int waits);
        logic [15:0] exp;
        for (int i = 0; i < waits; i++) begin
            chk("stall_req", {15'd0, imem_req}, 16'd1);
            chk("stall_addr", imem_addr, addr);
            imem_rdy = 1'b0;
            tick();
        end
        chk("req", {15'd0, imem_req}, 16'd1);
        chk("addr", imem_addr, addr);
        imem_rdy  = 1'b1;
        imem_err  = 1'b0;
        imem_data = data;
        sb_q.push_back(data);
        exp_stall += waits;
        tick();
        imem_rdy  = 1'b0;
        imem_data = 16'hDEAD;
        chk("instr_valid", {15'd0, instr_valid}, 16'd1);
        chk("no_req_valid", {15'd0, imem_req}, 16'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 16'd1, 16'd0);
        end else begin
            exp = sb_q.pop_front();
            chk("instr", instr, exp);
        end
    endtask

    task automatic retire_to(input logic [15:0] target);
        pc_load = 1'b1;
        PCwb    = target;
        tick();
        pc_load = 1'b0;
        exp_retire++;
    endtask

    initial begin
        rst_n = 1'b0; PCwb = 16'h0; pc_load = 1'b0; halt = 1'b0;
        imem_rdy = 1'b0; imem_data = 16'h0; imem_err = 1'b0;
        vecs[0] = '{16'h0040, 16'h1111, 3, 16'h0042};
        vecs[1] = '{16'h0100, 16'h2222, 0, 16'h0102};
        vecs[2] = '{16'hFFFE, 16'h3333, 1, 16'h0000};
        vecs[3] = '{16'h0000, 16'h4444, 0, 16'h0002};
        vecs[4] = '{16'h1234, 16'h5555, 2, 16'h1236};

        tick();
        tick();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_pc2", PC2, 16'h0002);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        chk("rst_retire_cnt", retire_cnt, 16'd0);
`endif

        // Reset release: IDLE, then REQ at PC 0 answered immediately.
        rst_n = 1'b1;
        tick();
        serve(16'h0000, 16'h4123, 0);
        chk("first_pc2", PC2, 16'h0002);

        for (int v = 0; v < 5; v++) begin
            // rdy during VALID must not disturb the presented instruction
            imem_rdy  = 1'b1;
            imem_data = 16'hBEEF;
            tick();
            imem_rdy = 1'b0;
            chk("hold_valid", {15'd0, instr_valid}, 16'd1);
            chk("hold_instr", instr, (v == 0) ? 16'h4123 : vecs[v-1].data);
            retire_to(vecs[v].pcwb);
            serve(vecs[v].pcwb, vecs[v].data, vecs[v].waits);
            chk("vec_pc2", PC2, vecs[v].exp_pc2);
`ifdef FETCH_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, 16'(exp_stall));
            chk("retire_cnt", retire_cnt, 16'(exp_retire));
`endif
        end

        // Halt retire: PC stays 0x1234, absorbing, later pc_load ignored.
        halt = 1'b1;
        retire_to(16'h0010);
        halt = 1'b0;
        chk("halted", {15'd0, halted}, 16'd1);
        chk("halt_valid", {15'd0, instr_valid}, 16'd0);
        chk("halt_addr", imem_addr, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            pc_load = 1'b1;
            PCwb    = 16'h0200;
            tick();
            chk("halt_sticky", {15'd0, halted}, 16'd1);
            chk("halt_no_req", {15'd0, imem_req}, 16'd0);
            chk("halt_pc", imem_addr, 16'h1234);
        end
        pc_load = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("halt_retire_cnt", retire_cnt, 16'(exp_retire));
`endif

        // Misaligned retire target.
        do_reset();
        serve(16'h0000, 16'h0101, 0);
        retire_to(16'h0033);
        for (int i = 0; i < 2; i++) begin
            chk("mis_err", {15'd0, err}, 16'd1);
            chk("mis_no_req", {15'd0, imem_req}, 16'd0);
            chk("mis_pc", imem_addr, 16'h0000);
            tick();
        end

        // Memory fault while waiting.
        do_reset();
        imem_rdy = 1'b0;
        tick();
        chk("wait_req", {15'd0, imem_req}, 16'd1);
        imem_rdy = 1'b1;
        imem_err = 1'b1;
        tick();
        imem_rdy = 1'b0;
        imem_err = 1'b0;
        chk("fault_err", {15'd0, err}, 16'd1);
        chk("fault_valid", {15'd0, instr_valid}, 16'd0);
        chk("fault_req", {15'd0, imem_req}, 16'd0);

        // Reset during WAIT with a response in the same cycle.
        do_reset();
        serve(16'h0000, 16'h0202, 0);
        retire_to(16'h0200);
        imem_rdy = 1'b0;
        tick();
        chk("pre_rst_addr", imem_addr, 16'h0200);
        rst_n     = 1'b0;
        imem_rdy  = 1'b1;
        imem_data = 16'hABCD;
        tick();
        imem_rdy = 1'b0;
        rst_n    = 1'b1;
        chk("wrst_valid", {15'd0, instr_valid}, 16'd0);
        chk("wrst_req", {15'd0, imem_req}, 16'd0);
        chk("wrst_addr", imem_addr, 16'h0000);
        chk("wrst_instr", instr, 16'h0800);
        tick();
        chk("wrst_req_after", {15'd0, imem_req}, 16'd1);
        chk("wrst_instr_after", instr, 16'h0800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
